// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute sequencer for the 8-bit mini CPU.
// Fetches over a req/ack port, holds a 4-entry register file and drives the ALU.
module cpu_ctrl #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [7:0]        imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero,
    output logic [7:0]        pc,
    output logic              retire,
    output logic              halted,
    output logic              zflag
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_EXEC,
        S_HALT
    } state_e;

    localparam logic [2:0] OP_JNZ  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_e                 state_q, state_d;
    logic [7:0]             pc_q, pc_d;
    logic                   req_q, req_d;
    logic [7:0]             addr_q, addr_d;
    logic [6:0]             ir_q, ir_d;
    logic [7:0]             imm_q, imm_d;
    logic [3:0][DATA_W-1:0] rf_q, rf_d;
    logic [2:0]             op_q, op_d;
    logic [DATA_W-1:0]      a_q, a_d;
    logic [DATA_W-1:0]      b_q, b_d;
    logic                   halted_q, halted_d;
    logic                   zflag_q, zflag_d;

    logic [2:0]        opc;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [DATA_W-1:0] ld_a;

    // ir_q keeps instruction bits [7:1]; bit 0 carries no meaning
    assign opc  = ir_q[6:4];
    assign rd   = ir_q[3:2];
    assign rs   = ir_q[1:0];
    assign ld_a = (opc == OP_JNZ) ? rf_q[rs] : rf_q[rd];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        ir_d     = ir_q;
        imm_d    = imm_q;
        rf_d     = rf_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        halted_d = halted_q;
        zflag_d  = zflag_q;
        retire   = 1'b0;
        unique case (state_q)
            S_FETCH, S_FETCH_IMM: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end else if (imem_ack) begin
                    req_d = 1'b0;
                    pc_d  = pc_q + 8'd1;
                    // imm is overwritten by the second byte when there is one
                    imm_d = imem_rdata;
                    if (state_q == S_FETCH) begin
                        ir_d    = imem_rdata[7:1];
                        state_d = S_DECODE;
                    end else begin
                        state_d = S_EXEC;
                        op_d    = opc;
                        a_d     = ld_a;
                        b_d     = rf_q[rs];
                    end
                end
            end
            S_DECODE: begin
                unique case (opc)
                    OP_JNZ, OP_LDI: state_d = S_FETCH_IMM;
                    OP_NOP: begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        retire   = 1'b1;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        state_d = S_EXEC;
                        op_d    = opc;
                        a_d     = ld_a;
                        b_d     = rf_q[rs];
                    end
                endcase
            end
            S_EXEC: begin
                retire  = 1'b1;
                state_d = S_FETCH;
                unique case (opc)
                    OP_JNZ: begin
                        if (alu_y[0]) pc_d = imm_q;
                    end
                    OP_LDI: rf_d[rd] = DATA_W'(imm_q);
                    default: begin
                        rf_d[rd] = alu_y;
                        zflag_d  = alu_zero;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= 8'h00;
            ir_q     <= '0;
            imm_q    <= 8'h00;
            rf_q     <= '0;
            op_q     <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            halted_q <= 1'b0;
            zflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            rf_q     <= rf_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            halted_q <= halted_d;
            zflag_q  <= zflag_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign zflag     = zflag_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: program-level bench for cpu_ctrl with an ISA reference model,
// a wait-state instruction memory and a behavioural ALU.
module tb_cpu_ctrl;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
    logic       alu_zero;
    logic [7:0] pc;
    logic       retire;
    logic       halted;
    logic       zflag;

    cpu_ctrl #(.RESET_PC(8'hFF), .DATA_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .pc(pc), .retire(retire), .halted(halted), .zflag(zflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_y = 8'h00;
        case (alu_op)
            3'b000: alu_y = alu_a + alu_b;
            3'b001: alu_y = alu_a - alu_b;
            3'b010: alu_y = alu_a & alu_b;
            3'b011: alu_y = alu_a | alu_b;
            3'b100: alu_y = {7'd0, alu_a != 8'h00};
            default: alu_y = 8'h00;
        endcase
        alu_zero = (alu_y == 8'h00);
    end

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mem [256];
    logic [7:0] prg [4][8] = '{
        '{8'hA0, 8'h05, 8'hA8, 8'h03, 8'h0A, 8'hE0, 8'hE0, 8'hE0},
        '{8'hA0, 8'h07, 8'hA8, 8'h07, 8'h22, 8'hE0, 8'hE0, 8'hE0},
        '{8'hA0, 8'h00, 8'hA8, 8'h01, 8'h22, 8'h00, 8'hE0, 8'hE0},
        '{8'hA0, 8'h03, 8'hA8, 8'h01, 8'h22, 8'h80, 8'h03, 8'hE0}
    };

    int         ws = 0;
    bit         spur = 0;
    int         wcnt = 0;
    int         cyc = 0;
    int         hs_bad = 0;
    logic       p_req = 1'b0;
    logic       p_ack = 1'b0;
    logic [7:0] p_addr = 8'h00;

    logic [7:0] f_addr[$];
    logic [2:0] r_op[$];
    logic [7:0] r_a[$];
    logic [7:0] r_b[$];
    int         r_cyc[$];

    logic [7:0] e_fetch[$];
    logic [2:0] e_op[$];
    logic [7:0] e_a[$];
    logic [7:0] e_b[$];
    int         e_lat[$];
    bit         e_z;
    logic [7:0] e_pc;

    // memory responder and observer, both at the falling edge
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                imem_ack   = (wcnt >= ws);
                imem_rdata = imem_ack ? mem[imem_addr] : 8'($urandom);
                wcnt++;
            end else begin
                wcnt       = 0;
                imem_ack   = spur && ($urandom_range(0, 1) == 1);
                imem_rdata = 8'($urandom);
            end
            #1;
            cyc++;
            if (!rst) begin
                if (imem_req && p_req && !p_ack && imem_addr !== p_addr) hs_bad++;
                if (imem_req && p_req && p_ack) hs_bad++;
                if (imem_req && imem_addr !== pc) hs_bad++;
                if (imem_req && imem_ack) f_addr.push_back(imem_addr);
                if (retire) begin
                    r_op.push_back(alu_op);
                    r_a.push_back(alu_a);
                    r_b.push_back(alu_b);
                    r_cyc.push_back(cyc);
                end
            end
            p_req  = imem_req;
            p_ack  = imem_ack;
            p_addr = imem_addr;
        end
    end

    // instruction-set model: one loop iteration per retired instruction
    task automatic model_run(input int ws_i);
        logic [7:0] p, ins, imm, a, b, res;
        logic [7:0] r [4];
        logic [2:0] opc;
        int         rd, rs;
        bit         done;
        e_fetch.delete(); e_op.delete(); e_a.delete(); e_b.delete(); e_lat.delete();
        p = 8'hFF; r = '{default: 8'h00}; e_z = 1'b0; done = 1'b0;
        for (int s = 0; s < 300 && !done; s++) begin
            e_fetch.push_back(p); ins = mem[p]; p = p + 8'd1;
            opc = ins[7:5]; rd = int'(ins[4:3]); rs = int'(ins[2:1]); imm = 8'h00;
            if (opc == 3'd4 || opc == 3'd5) begin
                e_fetch.push_back(p); imm = mem[p]; p = p + 8'd1;
            end
            a = r[rd]; b = r[rs];
            case (opc)
                3'd0: res = a + b;
                3'd1: res = a - b;
                3'd2: res = a & b;
                3'd3: res = a | b;
                default: res = 8'h00;
            endcase
            if (opc < 3'd4) begin r[rd] = res; e_z = (res == 8'h00); end
            if (opc == 3'd4) begin a = r[rs]; if (r[rs] != 8'h00) p = imm; end
            if (opc == 3'd5) r[rd] = imm;
            if (opc == 3'd7) done = 1'b1;
            e_op.push_back(opc); e_a.push_back(a); e_b.push_back(b);
            if (opc >= 3'd6) e_lat.push_back(3 + ws_i);
            else if (opc >= 3'd4) e_lat.push_back(6 + 2 * ws_i);
            else e_lat.push_back(4 + ws_i);
        end
        e_pc = p;
    endtask

    task automatic load_prog(input int k);
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
        for (int j = 0; j < 8; j++) mem[8'(8'hFF + j)] = prg[k][j];
    endtask

    task automatic run_prog(input int ws_i, input bit spur_i, output bit ok);
        rst = 1'b1; ws = ws_i; spur = spur_i;
        repeat (2) @(negedge clk);
        f_addr.delete(); r_op.delete(); r_a.delete(); r_b.delete(); r_cyc.delete();
        hs_bad = 0;
        model_run(ws_i);
        #3 rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk); #2;
            ok = halted;
        end
        repeat (8) @(negedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1; ws = 0; spur = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        n_chk++; if (pc !== 8'hFF) begin n_err++; $display("FAIL reset_pc got=%h want=ff", pc); end
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", imem_req); end
        n_chk++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got=%h want=00", imem_addr); end
        n_chk++; if ({alu_op, alu_a, alu_b} !== 19'd0) begin n_err++; $display("FAIL reset_alu got=%h want=0", {alu_op, alu_a, alu_b}); end
        n_chk++; if ({retire, halted, zflag} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b want=000", {retire, halted, zflag}); end
    endtask

    task automatic test_programs;
        bit ok;
        int nsub, nloop;
        for (int k = 0; k < 4; k++) begin
            load_prog(k);
            run_prog(0, 1'b0, ok);
            n_chk++; if (!ok) begin n_err++; $display("FAIL prog%0d halt got=0 want=1", k); end
            n_chk++; if (f_addr.size() != e_fetch.size()) begin n_err++; $display("FAIL prog%0d nfetch got=%0d want=%0d", k, f_addr.size(), e_fetch.size()); end
            foreach (e_fetch[i]) if (i < f_addr.size()) begin
                n_chk++; if (f_addr[i] !== e_fetch[i]) begin n_err++; $display("FAIL prog%0d fetch[%0d] got=%h want=%h", k, i, f_addr[i], e_fetch[i]); end
            end
            n_chk++; if (r_op.size() != e_op.size()) begin n_err++; $display("FAIL prog%0d nretire got=%0d want=%0d", k, r_op.size(), e_op.size()); end
            foreach (e_op[i]) if (i < r_op.size() && e_op[i] <= 3'd4) begin
                n_chk++; if ({r_op[i], r_a[i], r_b[i]} !== {e_op[i], e_a[i], e_b[i]}) begin n_err++; $display("FAIL prog%0d alu[%0d] got=%h want=%h", k, i, {r_op[i], r_a[i], r_b[i]}, {e_op[i], e_a[i], e_b[i]}); end
            end
            foreach (e_lat[i]) if (i > 0 && i < r_cyc.size()) begin
                n_chk++; if (r_cyc[i] - r_cyc[i-1] != e_lat[i]) begin n_err++; $display("FAIL prog%0d latency[%0d] got=%0d want=%0d", k, i, r_cyc[i] - r_cyc[i-1], e_lat[i]); end
            end
            n_chk++; if (zflag !== e_z) begin n_err++; $display("FAIL prog%0d zflag got=%b want=%b", k, zflag, e_z); end
            n_chk++; if (pc !== e_pc || halted !== 1'b1) begin n_err++; $display("FAIL prog%0d final_pc got=%h/%b want=%h/1", k, pc, halted, e_pc); end
            n_chk++; if (hs_bad != 0) begin n_err++; $display("FAIL prog%0d handshake got=%0d want=0", k, hs_bad); end
            case (k)
                0: begin
                    n_chk++; if (r_op.size() != 4 || r_op[2] !== 3'b000 || r_a[2] !== 8'h03) begin n_err++; $display("FAIL prog0 add_exec got=%0d/%b want=4/000", r_op.size(), (r_op.size() > 2) ? r_op[2] : 3'bxxx); end
                    n_chk++; if (zflag !== 1'b0) begin n_err++; $display("FAIL prog0 zflag6 got=%b want=0", zflag); end
                end
                1: begin
                    n_chk++; if (zflag !== 1'b1) begin n_err++; $display("FAIL prog1 sub_zero got=%b want=1", zflag); end
                end
                2: begin
                    n_chk++; if (r_a.size() < 4 || r_a[3] !== 8'hFF) begin n_err++; $display("FAIL prog2 underflow got=%h want=ff", (r_a.size() > 3) ? r_a[3] : 8'hxx); end
                end
                default: begin
                    nsub = 0; nloop = 0;
                    foreach (r_op[i]) if (r_op[i] == 3'b001) nsub++;
                    foreach (f_addr[i]) if (f_addr[i] == 8'h03) nloop++;
                    n_chk++; if (nsub != 3 || nloop != 3) begin n_err++; $display("FAIL prog3 loop got=%0d/%0d want=3/3", nsub, nloop); end
                end
            endcase
        end
    endtask

    task automatic test_wait_states;
        bit ok;
        logic [7:0] z_fetch[$];
        load_prog(3);
        run_prog(0, 1'b0, ok);
        z_fetch = f_addr;
        run_prog(3, 1'b1, ok);
        n_chk++; if (!ok) begin n_err++; $display("FAIL ws halt got=0 want=1"); end
        n_chk++; if (f_addr.size() != z_fetch.size()) begin n_err++; $display("FAIL ws nfetch got=%0d want=%0d", f_addr.size(), z_fetch.size()); end
        foreach (z_fetch[i]) if (i < f_addr.size()) begin
            n_chk++; if (f_addr[i] !== z_fetch[i]) begin n_err++; $display("FAIL ws fetch[%0d] got=%h want=%h", i, f_addr[i], z_fetch[i]); end
        end
        n_chk++; if (r_op.size() != e_op.size()) begin n_err++; $display("FAIL ws nretire got=%0d want=%0d", r_op.size(), e_op.size()); end
        foreach (e_lat[i]) if (i > 0 && i < r_cyc.size()) begin
            n_chk++; if (r_cyc[i] - r_cyc[i-1] != e_lat[i]) begin n_err++; $display("FAIL ws latency[%0d] got=%0d want=%0d", i, r_cyc[i] - r_cyc[i-1], e_lat[i]); end
        end
        n_chk++; if (hs_bad != 0) begin n_err++; $display("FAIL ws handshake got=%0d want=0", hs_bad); end
        n_chk++; if (pc !== e_pc || zflag !== e_z) begin n_err++; $display("FAIL ws final got=%h/%b want=%h/%b", pc, zflag, e_pc, e_z); end
    endtask

    task automatic test_random;
        bit ok;
        logic [7:0] p;
        int n, kind, w;
        bit sp;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
            p = 8'hFF; n = $urandom_range(5, 12);
            for (int j = 0; j < n; j++) begin
                kind = $urandom_range(0, 6);
                if (kind < 4) begin
                    mem[p] = {3'(kind), 5'($urandom)}; p = p + 8'd1;
                end else if (kind == 4) begin
                    mem[p] = {3'b101, 5'($urandom)}; mem[8'(p + 8'd1)] = 8'($urandom); p = p + 8'd2;
                end else if (kind == 5) begin
                    mem[p] = {3'b110, 5'($urandom)}; p = p + 8'd1;
                end else begin
                    mem[p] = {3'b100, 5'($urandom)}; mem[8'(p + 8'd1)] = 8'(p + 8'd2); p = p + 8'd2;
                end
            end
            mem[p] = {3'b111, 5'($urandom)};
            w = $urandom_range(0, 3); sp = 1'($urandom);
            run_prog(w, sp, ok);
            n_chk++; if (!ok) begin n_err++; $display("FAIL rand%0d halt got=0 want=1", t); end
            n_chk++; if (f_addr.size() != e_fetch.size()) begin n_err++; $display("FAIL rand%0d nfetch got=%0d want=%0d", t, f_addr.size(), e_fetch.size()); end
            foreach (e_fetch[i]) if (i < f_addr.size()) begin
                n_chk++; if (f_addr[i] !== e_fetch[i]) begin n_err++; $display("FAIL rand%0d fetch[%0d] got=%h want=%h", t, i, f_addr[i], e_fetch[i]); end
            end
            n_chk++; if (r_op.size() != e_op.size()) begin n_err++; $display("FAIL rand%0d nretire got=%0d want=%0d", t, r_op.size(), e_op.size()); end
            foreach (e_op[i]) if (i < r_op.size() && e_op[i] <= 3'd4) begin
                n_chk++; if ({r_op[i], r_a[i], r_b[i]} !== {e_op[i], e_a[i], e_b[i]}) begin n_err++; $display("FAIL rand%0d alu[%0d] got=%h want=%h", t, i, {r_op[i], r_a[i], r_b[i]}, {e_op[i], e_a[i], e_b[i]}); end
            end
            foreach (e_lat[i]) if (i > 0 && i < r_cyc.size()) begin
                n_chk++; if (r_cyc[i] - r_cyc[i-1] != e_lat[i]) begin n_err++; $display("FAIL rand%0d latency[%0d] got=%0d want=%0d", t, i, r_cyc[i] - r_cyc[i-1], e_lat[i]); end
            end
            n_chk++; if (zflag !== e_z) begin n_err++; $display("FAIL rand%0d zflag got=%b want=%b", t, zflag, e_z); end
            n_chk++; if (pc !== e_pc) begin n_err++; $display("FAIL rand%0d final_pc got=%h want=%h", t, pc, e_pc); end
            n_chk++; if (hs_bad != 0) begin n_err++; $display("FAIL rand%0d handshake got=%0d want=0", t, hs_bad); end
        end
    endtask

    task automatic test_reset_mid_fetch;
        bit ok;
        load_prog(0);
        rst = 1'b1; ws = 3; spur = 1'b0;
        @(negedge clk);
        #3 rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #2;
            ok = imem_req && (imem_addr == 8'h00);
        end
        n_chk++; if (!ok) begin n_err++; $display("FAIL midrst imm_fetch got=%b/%h want=1/00", imem_req, imem_addr); end
        n_chk++; if (pc !== 8'h00) begin n_err++; $display("FAIL midrst pc_wrap got=%h want=00", pc); end
        #1 rst = 1'b1;
        #1;
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL midrst req got=%b want=0", imem_req); end
        n_chk++; if (pc !== 8'hFF) begin n_err++; $display("FAIL midrst pc got=%h want=ff", pc); end
        run_prog(0, 1'b0, ok);
        n_chk++; if (!ok || r_op.size() != 4) begin n_err++; $display("FAIL midrst rerun got=%b/%0d want=1/4", ok, r_op.size()); end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
        test_reset();
        test_programs();
        test_wait_states();
        test_random();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
